// File: rtl/div4bit_seq_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The bench drives it through the master modport and the divider through the slave modport.
interface div4bit_seq_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;

  modport master (output start, a, b, input  q, r, busy, done, dbz);
  modport slave  (input  start, a, b, output q, r, busy, done, dbz);
endinterface

// File: rtl/div4bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, N steps per divide.
// Divide-by-zero bypasses the iteration and reports q = all ones, r = a, dbz = 1.
module div4bit_seq #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  div4bit_seq_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    rem_sh;
  logic [N:0]    rem_sub;
  logic          qbit;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    // The dividend register doubles as the quotient shift register; N+1-bit compare avoids overflow.
    rem_sh  = {rem_q[N-1:0], dvd_q[N-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    qbit    = (rem_sh >= {1'b0, dvs_q});

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.b == '0) begin
            q_d     = '1;
            r_d     = bus.a;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            dvd_d   = bus.a;
            dvs_d   = bus.b;
            rem_d   = '0;
            cnt_d   = CW'(N);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = qbit ? rem_sub : rem_sh;
        dvd_d = {dvd_q[N-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = dvd_d;
          r_d     = rem_d[N-1:0];
          dbz_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_div4bit_seq.sv
// Scoreboard bench for div4bit_seq: expected results are queued at issue time and
// compared, including the cycle on which done must appear, when done pulses.
module tb_div4bit_seq;
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         done_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t mon_e;

  div4bit_seq_if #(.N(4)) bus ();

  div4bit_seq #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input int done_cyc);
    exp_t e;
    if (bv == 4'd0) begin
      e.q   = 4'hF;
      e.r   = av;
      e.dbz = 1'b1;
    end else begin
      e.q   = av / bv;
      e.r   = av % bv;
      e.dbz = 1'b0;
    end
    e.done_cyc = done_cyc;
    return e;
  endfunction

  // Must be called at a negedge with the DUT idle; returns one negedge later with start low.
  task automatic issue(input logic [3:0] av, input logic [3:0] bv, input bit push);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    if (push) sb.push_back(model(av, bv, cyc + 1 + ((bv == 4'd0) ? 0 : 4)));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_excl", {31'b0, bus.busy & bus.done}, 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          mon_e = sb.pop_front();
          check("q", bus.q, mon_e.q);
          check("r", bus.r, mon_e.r);
          check("dbz", bus.dbz, mon_e.dbz);
          check("done_cycle", cyc, mon_e.done_cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x;
    logic [3:0] av, bv;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(negedge clk);
    check("rst_q", bus.q, 0);
    check("rst_r", bus.r, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.dbz, 0);
    rst = 1'b0;
    @(negedge clk);

    // 13/3: busy across E0..E3 sampling points, done 4 edges after accept
    issue(4'd13, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("s1_busy", bus.busy, 1);
      check("s1_q_hold", bus.q, 0);
      if (i < 3) @(negedge clk);
    end
    drain();

    issue(4'd15, 4'd1, 1'b1);
    drain();
    issue(4'd2, 4'd7, 1'b1);
    drain();

    issue(4'd9, 4'd0, 1'b1);
    check("s3_no_busy", bus.busy, 0);
    drain();
    issue(4'd6, 4'd2, 1'b1);
    drain();

    // 12/5 with an ignored start at E2; previous result 3 r0 must hold during RUN
    issue(4'd12, 4'd5, 1'b1);
    check("s4_q_hold", bus.q, 3);
    check("s4_r_hold", bus.r, 0);
    @(negedge clk);
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    bus.start = 1'b1;
    check("s4_q_hold", bus.q, 3);
    @(negedge clk);
    bus.start = 1'b0;
    check("s4_q_hold", bus.q, 3);
    check("s4_r_hold", bus.r, 0);
    check("s4_busy", bus.busy, 1);
    drain();

    // 14/3 aborted by reset at E2; no done may follow
    issue(4'd14, 4'd3, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("s5_rst_q", bus.q, 0);
    check("s5_rst_r", bus.r, 0);
    check("s5_rst_busy", bus.busy, 0);
    check("s5_rst_done", bus.done, 0);
    check("s5_rst_dbz", bus.dbz, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(4'd7, 4'd2, 1'b1);
    drain();

    // Exhaustive sweep, start held high: accepts every 6 cycles, or 2 after a b=0 request
    x = cyc + 1;
    bus.start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      av    = 4'(k >> 4);
      bv    = 4'(k & 15);
      bus.a = av;
      bus.b = bv;
      sb.push_back(model(av, bv, x + ((bv == 4'd0) ? 0 : 4)));
      repeat (x - cyc) @(posedge clk);
      @(negedge clk);
      x = x + ((bv == 4'd0) ? 2 : 6);
    end
    bus.start = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
